// File: rtl/lcd_ctrl.sv
// HD44780-style character LCD write controller: buffers LSU writes in a small FIFO
// and replays each entry as a timed RS/DATA/EN bus cycle followed by an execution wait.
module lcd_ctrl #(
  parameter int unsigned PWRUP_CYC  = 750000,
  parameter int unsigned SETUP_CYC  = 2,
  parameter int unsigned PULSE_CYC  = 25,
  parameter int unsigned HOLD_CYC   = 2,
  parameter int unsigned EXEC_CYC   = 2000,
  parameter int unsigned LONG_CYC   = 82000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        i_rst,
  input  logic        i_wr,
  input  logic [8:0]  i_wdata,
  input  logic        i_on,
  output logic [7:0]  o_lcd_data,
  output logic        o_lcd_rs,
  output logic        o_lcd_rw,
  output logic        o_lcd_en,
  output logic        o_lcd_on,
  output logic        o_busy,
  output logic        o_full,
  output logic        o_ovf,
  output logic [31:0] o_status
);

  localparam int unsigned MAX_A   = (PWRUP_CYC > LONG_CYC) ? PWRUP_CYC : LONG_CYC;
  localparam int unsigned MAX_B   = (EXEC_CYC > PULSE_CYC) ? EXEC_CYC : PULSE_CYC;
  localparam int unsigned MAX_C   = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
  localparam int unsigned MAX_AB  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CNT_MAX = (MAX_AB > MAX_C) ? MAX_AB : MAX_C;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned OCC_W   = PTR_W + 1;

  typedef enum logic [2:0] {
    S_PWRUP, S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_WAIT
  } state_e;

  // Counter holds "cycles remaining minus one", so a phase of N cycles loads N-1.
  function automatic logic [CNT_W-1:0] ld(input int unsigned n);
    return CNT_W'(n - 1);
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             en_q, en_d;
  logic             on_q, on_d;
  logic [8:0]       data_q, data_d;
  logic [8:0]       mem_q [FIFO_DEPTH];

  logic full, push, pop, long_cmd;
  logic [8:0] rd_data;

  assign full     = (count_q == OCC_W'(FIFO_DEPTH));
  assign push     = i_wr && !full;
  assign pop      = (state_q == S_IDLE) && (count_q != '0);
  assign rd_data  = mem_q[rd_ptr_q];
  assign long_cmd = !data_q[8] && ((data_q[7:0] == 8'h01) || (data_q[7:0] == 8'h02));

  always_comb begin : fifo_next
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
    ovf_d = ovf_q || (i_wr && full);
  end

  // NOTE: storage is not reset; count and pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push && !i_rst) mem_q[wr_ptr_q] <= i_wdata;
  end

  always_comb begin : fsm_next
    state_d = state_q;
    cnt_d   = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    unique case (state_q)
      S_PWRUP: if (cnt_q == '0) state_d = S_IDLE;
      S_IDLE:  if (pop) begin state_d = S_SETUP; cnt_d = ld(SETUP_CYC); end
      S_SETUP: if (cnt_q == '0) begin state_d = S_PULSE; cnt_d = ld(PULSE_CYC); end
      S_PULSE: if (cnt_q == '0) begin state_d = S_HOLD;  cnt_d = ld(HOLD_CYC); end
      S_HOLD:  if (cnt_q == '0) begin
                 state_d = S_WAIT;
                 cnt_d   = long_cmd ? ld(LONG_CYC) : ld(EXEC_CYC);
               end
      S_WAIT:  if (cnt_q == '0) state_d = S_IDLE;
      default: begin state_d = S_PWRUP; cnt_d = ld(PWRUP_CYC); end
    endcase
  end

  // EN is registered from the next state so the pin comes straight off a flop.
  always_comb begin : out_next
    en_d   = (state_d == S_PULSE);
    data_d = pop ? rd_data : data_q;
    on_d   = i_on;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q  <= S_PWRUP;
      cnt_q    <= ld(PWRUP_CYC);
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      en_q     <= 1'b0;
      on_q     <= 1'b0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      en_q     <= en_d;
      on_q     <= on_d;
      data_q   <= data_d;
    end
  end

  assign o_lcd_data = data_q[7:0];
  assign o_lcd_rs   = data_q[8];
  assign o_lcd_rw   = 1'b0;
  assign o_lcd_en   = en_q;
  assign o_lcd_on   = on_q;
  assign o_busy     = (state_q != S_IDLE) || (count_q != '0);
  assign o_full     = full;
  assign o_ovf      = ovf_q;
  assign o_status   = {29'b0, ovf_q, full, o_busy};

endmodule
